// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one AXI
// transaction out, one held response back to the requester.
module axi_lite_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                cmd_valid,
    output logic                CMD_READY,
    input  logic                cmd_we,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_wstrb,
    output logic                RSP_VALID,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   RSP_RDATA,
    output logic [1:0]          RSP_RESP,
    output logic                RSP_WE,
    output logic                BUSY,
    output logic [ADDR_W-1:0]   AW_ADDR,
    output logic                AW_VALID,
    input  logic                aw_ready,
    output logic [DATA_W-1:0]   W_DATA,
    output logic [DATA_W/8-1:0] W_STRB,
    output logic                W_VALID,
    input  logic                w_ready,
    input  logic [1:0]          b_resp,
    input  logic                b_valid,
    output logic                B_READY,
    output logic [ADDR_W-1:0]   AR_ADDR,
    output logic                AR_VALID,
    input  logic                ar_ready,
    input  logic [DATA_W-1:0]   r_data,
    input  logic [1:0]          r_resp,
    input  logic                r_valid,
    output logic                R_READY
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RESP
    } state_e;

    state_e              state_q, state_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                busy_q, busy_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                aw_valid_q, aw_valid_d;
    logic                w_valid_q, w_valid_d;
    logic                b_ready_q, b_ready_d;
    logic                ar_valid_q, ar_valid_d;
    logic                r_ready_q, r_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]          rsp_resp_q, rsp_resp_d;
    logic                rsp_we_q, rsp_we_d;

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        aw_valid_d  = aw_valid_q;
        w_valid_d   = w_valid_q;
        b_ready_d   = b_ready_q;
        ar_valid_d  = ar_valid_q;
        r_ready_d   = r_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        rsp_we_d    = rsp_we_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_wdata;
                    wstrb_d     = cmd_wstrb;
                    cmd_ready_d = 1'b0;
                    if (cmd_we) begin
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                        state_d    = WR_REQ;
                    end else begin
                        ar_valid_d = 1'b1;
                        state_d    = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                // AW and W retire independently, in either order
                if (aw_valid_q && aw_ready) aw_valid_d = 1'b0;
                if (w_valid_q && w_ready)   w_valid_d  = 1'b0;
                if (!aw_valid_d && !w_valid_d) begin
                    b_ready_d = 1'b1;
                    state_d   = WR_RESP;
                end
            end
            WR_RESP: begin
                if (b_valid) begin
                    rsp_resp_d  = b_resp;
                    rsp_rdata_d = '0;
                    rsp_we_d    = 1'b1;
                    b_ready_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RD_REQ: begin
                if (ar_ready) begin
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                    state_d    = RD_DATA;
                end
            end
            RD_DATA: begin
                if (r_valid) begin
                    rsp_rdata_d = r_data;
                    rsp_resp_d  = r_resp;
                    rsp_we_d    = 1'b0;
                    r_ready_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            b_ready_q   <= 1'b0;
            ar_valid_q  <= 1'b0;
            r_ready_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
            rsp_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            aw_valid_q  <= aw_valid_d;
            w_valid_q   <= w_valid_d;
            b_ready_q   <= b_ready_d;
            ar_valid_q  <= ar_valid_d;
            r_ready_q   <= r_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            rsp_we_q    <= rsp_we_d;
        end
    end

    assign CMD_READY = cmd_ready_q;
    assign BUSY      = busy_q;
    assign AW_ADDR   = addr_q;
    assign AR_ADDR   = addr_q;
    assign W_DATA    = wdata_q;
    assign W_STRB    = wstrb_q;
    assign AW_VALID  = aw_valid_q;
    assign W_VALID   = w_valid_q;
    assign B_READY   = b_ready_q;
    assign AR_VALID  = ar_valid_q;
    assign R_READY   = r_ready_q;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_RDATA = rsp_rdata_q;
    assign RSP_RESP  = rsp_resp_q;
    assign RSP_WE    = rsp_we_q;

endmodule
